// File: rtl/multicycle_left_shifter_4b.sv
// Multicycle left shifter: one bit per clock, with a fill bit, the last bit shifted out,
// and a sticky overflow flag. A three-state FSM sequences load, shift and a one-cycle done pulse.
module multicycle_left_shifter_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       amt,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic             cin_reg, cin_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic [WIDTH-1:0] shifted;

  // One-position left shift with the latched fill bit entering at bit 0.
  assign shifted[0] = cin_reg;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign shifted[gi] = out_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      cnt_reg   <= '0;
      cin_reg   <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      cnt_reg   <= cnt_next;
      cin_reg   <= cin_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    cnt_next   = cnt_reg;
    cin_next   = cin_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          out_next   = in;
          cnt_next   = amt;
          cin_next   = cin;
          cout_next  = 1'b0;
          ovf_next   = 1'b0;
          state_next = (amt == 3'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        out_next  = shifted;
        cout_next = out_reg[WIDTH-1];
        ovf_next  = ovf_reg | out_reg[WIDTH-1];
        cnt_next  = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs are pure state decodes so they never glitch relative to the data.
  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign out  = out_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_multicycle_left_shifter_4b.sv
// Directed self-checking bench for multicycle_left_shifter_4b.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_multicycle_left_shifter_4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] in;
  logic [2:0] amt;
  logic       cin;
  logic [3:0] out;
  logic       cout;
  logic       ovf;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  multicycle_left_shifter_4b #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in   (in),
    .amt  (amt),
    .cin  (cin),
    .out  (out),
    .cout (cout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for exactly one accepting edge; afterwards we sit in the cycle after acceptance.
  task automatic launch(input logic [3:0] i, input logic [2:0] a, input logic c);
    in    = i;
    amt   = a;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // lat counts cycles after the accepting edge until done is seen (bounded at 64).
  task automatic wait_done(output int lat, output int bcy);
    lat = 1;
    bcy = 0;
    while (!done && lat < 64) begin
      if (busy) bcy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in = 4'b0000; amt = 3'd0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (out !== 4'b0000) begin
      failures++; $display("FAIL reset_out: got %b expected 0000", out);
    end
    checks++;
    if ({cout, ovf, busy, done} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got cout/ovf/busy/done=%b expected 0000", {cout, ovf, busy, done});
    end
    $display("reset: out=%b cout=%b ovf=%b busy=%b done=%b", out, cout, ovf, busy, done);
  endtask

  task automatic test_amt_zero();
    int lat, bcy;
    launch(4'b0110, 3'd0, 1'b0);
    wait_done(lat, bcy);
    $display("op in=0110 amt=0 cin=0 -> out=%b cout=%b ovf=%b lat=%0d", out, cout, ovf, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL amt0_latency: got %0d expected 1", lat); end
    checks++;
    if (bcy !== 0) begin failures++; $display("FAIL amt0_busy: got %0d busy cycles expected 0", bcy); end
    checks++;
    if ({out, cout, ovf} !== 6'b0110_0_0) begin
      failures++; $display("FAIL amt0_result: got out=%b cout=%b ovf=%b expected 0110/0/0", out, cout, ovf);
    end
    tick();
    checks++;
    if (done !== 1'b0 || out !== 4'b0110) begin
      failures++; $display("FAIL amt0_after_done: got done=%b out=%b expected 0/0110", done, out);
    end
  endtask

  task automatic test_single_shift();
    logic [3:0] vin  [2] = '{4'b1010, 4'b1011};
    logic       vcin [2] = '{1'b0, 1'b1};
    logic [3:0] vout [2] = '{4'b0100, 4'b0111};
    int lat, bcy;
    for (int n = 0; n < 2; n++) begin
      launch(vin[n], 3'd1, vcin[n]);
      wait_done(lat, bcy);
      $display("op in=%b amt=1 cin=%b -> out=%b cout=%b ovf=%b lat=%0d", vin[n], vcin[n], out, cout, ovf, lat);
      checks++;
      if (lat !== 2 || bcy !== 1) begin
        failures++; $display("FAIL single_timing[%0d]: got lat=%0d busy=%0d expected 2/1", n, lat, bcy);
      end
      checks++;
      if ({out, cout, ovf} !== {vout[n], 1'b1, 1'b1}) begin
        failures++; $display("FAIL single_result[%0d]: got %b/%b/%b expected %b/1/1", n, out, cout, ovf, vout[n]);
      end
      tick();
    end
  endtask

  task automatic test_multi_shift();
    logic [3:0] mid [3] = '{4'b0111, 4'b1111, 4'b1111};
    launch(4'b1011, 3'd3, 1'b1);
    checks++;
    if (busy !== 1'b1 || out !== 4'b1011) begin
      failures++; $display("FAIL multi_load: got busy=%b out=%b expected 1/1011", busy, out);
    end
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (out !== mid[s] || busy !== (s < 2) || done !== (s == 2)) begin
        failures++; $display("FAIL multi_step[%0d]: got out=%b busy=%b done=%b expected %b/%b/%b",
                             s, out, busy, done, mid[s], (s < 2), (s == 2));
      end
    end
    $display("op in=1011 amt=3 cin=1 -> out=%b cout=%b ovf=%b", out, cout, ovf);
    checks++;
    if (cout !== 1'b1 || ovf !== 1'b1) begin
      failures++; $display("FAIL multi_flags: got cout=%b ovf=%b expected 1/1", cout, ovf);
    end
    in = 4'b0000; amt = 3'd7; cin = 1'b0;
    tick();
    checks++;
    if ({out, cout, ovf, busy, done} !== 8'b1111_1_1_0_0) begin
      failures++; $display("FAIL multi_hold: got out=%b cout=%b ovf=%b busy=%b done=%b expected 1111/1/1/0/0",
                           out, cout, ovf, busy, done);
    end
  endtask

  task automatic test_beyond_width();
    int lat, bcy;
    launch(4'b1001, 3'd6, 1'b0);
    wait_done(lat, bcy);
    $display("op in=1001 amt=6 cin=0 -> out=%b cout=%b ovf=%b lat=%0d", out, cout, ovf, lat);
    checks++;
    if (lat !== 7 || bcy !== 6) begin
      failures++; $display("FAIL wide_timing: got lat=%0d busy=%0d expected 7/6", lat, bcy);
    end
    checks++;
    if ({out, cout, ovf} !== 6'b0000_0_1) begin
      failures++; $display("FAIL wide_result: got %b/%b/%b expected 0000/0/1", out, cout, ovf);
    end
    tick();
  endtask

  task automatic test_interference();
    int lat, bcy;
    launch(4'b0011, 3'd5, 1'b0);
    tick();
    in = 4'b1111; amt = 3'd1; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bcy);
    $display("op in=0011 amt=5 cin=0 (restart ignored) -> out=%b cout=%b ovf=%b lat=%0d", out, cout, ovf, lat + 2);
    checks++;
    if (lat + 2 !== 6) begin failures++; $display("FAIL interf_latency: got %0d expected 6", lat + 2); end
    checks++;
    if ({out, cout, ovf} !== 6'b0000_0_1) begin
      failures++; $display("FAIL interf_result: got %b/%b/%b expected 0000/0/1", out, cout, ovf);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 4'b0000) begin
      failures++; $display("FAIL interf_idle: got busy=%b done=%b out=%b expected 0/0/0000", busy, done, out);
    end
  endtask

  task automatic test_abort();
    int lat, bcy;
    launch(4'b1100, 3'd5, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("abort: out=%b cout=%b ovf=%b busy=%b done=%b", out, cout, ovf, busy, done);
    checks++;
    if ({out, cout, ovf, busy, done} !== 8'b0) begin
      failures++; $display("FAIL abort_clear: got out=%b cout=%b ovf=%b busy=%b done=%b expected all 0",
                           out, cout, ovf, busy, done);
    end
    launch(4'b0001, 3'd2, 1'b1);
    wait_done(lat, bcy);
    $display("op in=0001 amt=2 cin=1 -> out=%b cout=%b ovf=%b lat=%0d", out, cout, ovf, lat);
    checks++;
    if (lat !== 3 || {out, cout, ovf} !== 6'b0111_0_0) begin
      failures++; $display("FAIL abort_next: got lat=%0d %b/%b/%b expected 3 0111/0/0", lat, out, cout, ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bcy;
    launch(4'b1000, 3'd1, 1'b0);
    wait_done(lat, bcy);
    $display("op in=1000 amt=1 cin=0 -> out=%b cout=%b ovf=%b lat=%0d", out, cout, ovf, lat);
    checks++;
    if (lat !== 2 || {out, cout, ovf} !== 6'b0000_1_1) begin
      failures++; $display("FAIL b2b_first: got lat=%0d %b/%b/%b expected 2 0000/1/1", lat, out, cout, ovf);
    end
    tick();
    launch(4'b0001, 3'd2, 1'b0);
    wait_done(lat, bcy);
    $display("op in=0001 amt=2 cin=0 -> out=%b cout=%b ovf=%b lat=%0d", out, cout, ovf, lat);
    checks++;
    if (lat !== 3 || {out, cout, ovf} !== 6'b0100_0_0) begin
      failures++; $display("FAIL b2b_second: got lat=%0d %b/%b/%b expected 3 0100/0/0", lat, out, cout, ovf);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in = 4'b0000; amt = 3'd0; cin = 1'b0;
    test_reset();
    test_amt_zero();
    test_single_shift();
    test_multi_shift();
    test_beyond_width();
    test_interference();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_left_shifter_4b.md
MULTICYCLE_LEFT_SHIFTER_4B -- requirements
Module: multicycle_left_shifter_4b

Interface
REQ-001 Parameter WIDTH, default 4: data width in bits; all statements below use WIDTH=4.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 in  input  WIDTH  operand; latched when start is accepted.
REQ-006 amt  input  3  shift count, 0..7; latched when start is accepted.
REQ-007 cin  input  1  fill bit inserted at bit 0 on every shift; latched when start is accepted.
REQ-008 out  output  WIDTH  registered shift result.
REQ-009 cout  output  1  registered last bit shifted out of bit WIDTH-1.
REQ-010 ovf  output  1  registered sticky OR of every bit shifted out during the current operation.
REQ-011 busy  output  1  high while shifting.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, SHIFT, DONE; all outputs SHALL be registered or decoded from state only.
REQ-014 IDLE with start=1 SHALL, on that edge, load out<=in, cnt<=amt, cin_r<=cin, cout<=0 and ovf<=0.
REQ-015 On that same edge, IDLE SHALL go to SHIFT if amt!=0 and to DONE if amt==0.
REQ-016 IDLE with start=0 SHALL hold all registers.
REQ-017 Each SHIFT edge SHALL apply out<={out[WIDTH-2:0],cin_r}, cout<=out[WIDTH-1], ovf<=ovf|out[WIDTH-1] and cnt<=cnt-1.
REQ-018 SHIFT SHALL go to DONE on the edge where cnt==1; otherwise it SHALL remain in SHIFT.
REQ-019 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-020 busy SHALL be 1 iff state==SHIFT; done SHALL be 1 iff state==DONE.
REQ-021 Latency: done SHALL be high in the cycle after edge k+amt, where k is the accepting edge; for amt==0, done SHALL be high in the cycle after edge k.
REQ-022 start SHALL be ignored in SHIFT and DONE; changes to in, amt and cin after acceptance SHALL NOT affect the running operation.
REQ-023 out, cout and ovf SHALL hold their final values from DONE until the next accepted start.
REQ-024 amt>=WIDTH SHALL be legal: out ends as WIDTH copies of cin_r, and cout and ovf follow REQ-017 for every shift.
REQ-025 A start in the cycle immediately after done SHALL be accepted (back-to-back operation, one IDLE cycle minimum).

Reset
REQ-026 rst=1 at an edge SHALL force state=IDLE and out=0, cout=0, ovf=0, busy=0, done=0, cnt=0, cin_r=0, overriding start and any in-progress operation.
REQ-027 After rst deasserts, the first start SHALL be accepted with no extra delay cycles.

Verification
REQ-028 Bench SHALL cover reset values: assert rst for 2 cycles -> out=0000, cout=0, ovf=0, busy=0, done=0.
REQ-029 Bench SHALL cover amt=0: in=0110, amt=0, cin=0, start -> done high 1 cycle after accept, busy never high, out=0110, cout=0, ovf=0.
REQ-030 Bench SHALL cover single shifts:
- in=1010, amt=1, cin=0 -> out=0100, cout=1, ovf=1.
- in=1011, amt=1, cin=1 -> out=0111, cout=1, ovf=1.
- In both cases busy is high 1 cycle and done is high 2 cycles after accept.
REQ-031 Bench SHALL cover multi-shift: in=1011, amt=3, cin=1 -> intermediate out 0111/1111/1111, final out=1111, cout=1, ovf=1, busy high 3 cycles, done 4 cycles after accept.
REQ-032 Bench SHALL cover amt beyond width: in=1001, amt=6, cin=0 -> out=0000, cout=0, ovf=1, done 7 cycles after accept.
REQ-033 Bench SHALL cover interference and abort:
- During a start with amt=5, re-pulse start with different in/amt/cin -> ignored, and the original result completes.
- Assert rst in the 2nd SHIFT cycle -> next cycle state=IDLE with all outputs 0, and a following start operates normally.
